// File: rtl/divisor_pkg.sv
// Shared types and constants for the sequential integer divider.
// Holds the controller state encoding and the default operand width.
package divisor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } estado_t;

   localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/division_restauradora.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first.
// Operands are snapshotted on start; results and a done pulse appear after FIN.
module division_restauradora
   import divisor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividendo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] cociente,
   output logic [WIDTH-1:0] resto,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_INI = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_UNO = CW'(1);

   estado_t          state_r;
   estado_t          state_s;
   logic [WIDTH-1:0] dvd_r;
   logic [WIDTH-1:0] dvs_r;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] cociente_r;
   logic [WIDTH-1:0] resto_r;
   logic [WIDTH:0]   r_r;
   logic [WIDTH:0]   r_shift_s;
   logic [WIDTH:0]   r_next_s;
   logic [CW-1:0]    cnt_r;
   logic             ge_s;
   logic             busy_r;
   logic             done_r;

   // Controller state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Controller next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_s = CALC;
            else       state_s = IDLE;
         end
         CALC: begin
            if (cnt_r == '0) state_s = FIN;
            else             state_s = CALC;
         end
         FIN:     state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Single restoring step: shift in the next dividend bit, then compare/subtract
   always_comb begin
      r_shift_s = {r_r[WIDTH-1:0], dvd_r[cnt_r]};
      ge_s      = (r_shift_s >= {1'b0, dvs_r});
      if (ge_s) r_next_s = r_shift_s - {1'b0, dvs_r};
      else      r_next_s = r_shift_s;
   end

   // Working registers, counter and result/flag outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         dvd_r      <= '0;
         dvs_r      <= '0;
         q_r        <= '0;
         r_r        <= '0;
         cnt_r      <= '0;
         cociente_r <= '0;
         resto_r    <= '0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         done_r <= 1'b0;
         busy_r <= (state_s != IDLE);
         case (state_r)
            IDLE: begin
               if (start) begin
                  dvd_r <= dividendo;
                  dvs_r <= divisor;
                  r_r   <= '0;
                  q_r   <= '0;
                  cnt_r <= CNT_INI;
               end
            end
            CALC: begin
               r_r <= r_next_s;
               q_r <= {q_r[WIDTH-2:0], ge_s};
               if (cnt_r != '0) cnt_r <= cnt_r - CNT_UNO;
            end
            FIN: begin
               cociente_r <= q_r;
               resto_r    <= r_r[WIDTH-1:0];
               done_r     <= 1'b1;
            end
            default: begin
               done_r <= 1'b0;
            end
         endcase
      end
   end

   assign cociente = cociente_r;
   assign resto    = resto_r;
   assign busy     = busy_r;
   assign done     = done_r;

endmodule

// File: rtl/divisor_entero_secuencial_chk.sv
// Property checker for the divider front end: the divisor must never be zero.
module divisor_entero_secuencial_chk
   import divisor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic             clock,
   input logic             reset,
   input logic [WIDTH-1:0] divisor
);

   a_divisor_no_cero: assert property (@(posedge clock) disable iff (reset) divisor != '0)
      else $error("divisor reached zero");

endmodule

// File: rtl/divisor_entero_secuencial.sv
// Divider front end: button edge detection and operand editing around the
// restoring division core.
module divisor_entero_secuencial
   import divisor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             up,
   input  logic             down,
   input  logic             selector,
   input  logic             start,
   output logic [WIDTH-1:0] numerador,
   output logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] cociente,
   output logic [WIDTH-1:0] resto,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] MAXV = '1;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   logic             up_prev_r;
   logic             down_prev_r;
   logic             up_edge_s;
   logic             down_edge_s;
   logic [WIDTH-1:0] numerador_r;
   logic [WIDTH-1:0] divisor_r;
   logic [WIDTH-1:0] numerador_s;
   logic [WIDTH-1:0] divisor_s;
   logic             busy_s;

   // Button history for rising-edge detection
   always_ff @(posedge clock) begin
      if (reset) begin
         up_prev_r   <= 1'b0;
         down_prev_r <= 1'b0;
      end else begin
         up_prev_r   <= up;
         down_prev_r <= down;
      end
   end

   // Operand edit: numerador wraps modulo 2^WIDTH, divisor skips zero
   always_comb begin
      numerador_s = numerador_r;
      divisor_s   = divisor_r;
      up_edge_s   = up & ~up_prev_r;
      down_edge_s = down & ~down_prev_r;
      if (!busy_s && (up_edge_s ^ down_edge_s)) begin
         if (selector == 1'b0) begin
            if (up_edge_s) numerador_s = numerador_r + ONE;
            else           numerador_s = numerador_r - ONE;
         end else begin
            if (up_edge_s) begin
               if (divisor_r == MAXV) divisor_s = ONE;
               else                   divisor_s = divisor_r + ONE;
            end else begin
               if (divisor_r == ONE) divisor_s = MAXV;
               else                  divisor_s = divisor_r - ONE;
            end
         end
      end else begin
         numerador_s = numerador_r;
         divisor_s   = divisor_r;
      end
   end

   // Displayed operand registers
   always_ff @(posedge clock) begin
      if (reset) begin
         numerador_r <= '0;
         divisor_r   <= ONE;
      end else begin
         numerador_r <= numerador_s;
         divisor_r   <= divisor_s;
      end
   end

   division_restauradora #(
      .WIDTH (WIDTH)
   ) u_core (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .dividendo (numerador_r),
      .divisor   (divisor_r),
      .cociente  (cociente),
      .resto     (resto),
      .busy      (busy_s),
      .done      (done)
   );

   assign numerador = numerador_r;
   assign divisor   = divisor_r;
   assign busy      = busy_s;

endmodule
